// File: rtl/mult_div_unit_pkg.sv
// Shared opcode and state encodings for the E-stage multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MduNone  = 3'd0,
    MduMult  = 3'd1,
    MduMultu = 3'd2,
    MduDiv   = 3'd3,
    MduDivu  = 3'd4,
    MduMthi  = 3'd5,
    MduMtlo  = 3'd6
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } mdu_state_e;

  function automatic logic is_mult(mdu_op_e op);
    return (op == MduMult) || (op == MduMultu);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational datapath: signed/unsigned 64-bit product and 32-bit divide.
// Result is packed {hi, lo}; for divides hi is the remainder, lo the quotient.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_e     op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_u, q_u, r_u;
  logic [31:0] a_mag, b_mag, div_s, q_m, r_m, q_s, r_s;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on zero so the dividers never see an undefined case.
  assign div_zero = (b == 32'd0);
  assign div_u    = div_zero ? 32'd1 : b;
  assign q_u      = a / div_u;
  assign r_u      = a % div_u;

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;
  assign div_s = div_zero ? 32'd1 : b_mag;
  assign q_m   = a_mag / div_s;
  assign r_m   = a_mag % div_s;
  assign q_s   = (a[31] ^ b[31]) ? (~q_m + 32'd1) : q_m;
  assign r_s   = a[31] ? (~r_m + 32'd1) : r_m;

  always_comb begin
    result = '0;
    case (op)
      MduMult:  result = prod_s;
      MduMultu: result = prod_u;
      MduDiv:   result = {r_s, q_s};
      MduDivu:  result = {r_u, q_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div over a fixed latency
// and reports a registered Busy to the hazard unit.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MultLat = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLat  = 4'(DIV_CYCLES);

  mdu_op_e     op;
  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        skip_q, skip_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] arith_result;
  logic        arith_div_zero;

  assign op = mdu_op_e'(MDUCtrl);

  mdu_arith u_arith (
    .a        (A),
    .b        (B),
    .op       (op),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    skip_d    = skip_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (MDUEN) begin
          if (is_mult(op) || is_div(op)) begin
            pend_hi_d = arith_result[63:32];
            pend_lo_d = arith_result[31:0];
            // Divide by zero still burns the full latency but never commits.
            skip_d    = is_div(op) && arith_div_zero;
            cnt_d     = is_div(op) ? DivLat : MultLat;
            state_d   = StRun;
          end else if (op == MduMthi) begin
            hi_d = A;
          end else if (op == MduMtlo) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (!skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      skip_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      skip_q    <= skip_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the E stage of the P6 pipeline. It accepts the `MDUEN`/`MDUCtrl` command that the main decoder produces for mult, multu, div, divu, mthi and mtlo, and executes it over a fixed multi-cycle latency. It holds the architectural HI/LO registers and reports `Busy` so the hazard unit can stall later MDU instructions. It is the consumer end of the decoder's MDU control interface.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `MDUEN`, input, 1: command valid for the instruction currently in E.
- `MDUCtrl`, input, 3: operation code (`mduMult`, `mduMultu`, `mduDiv`, `mduDivu`, `mduMthi`, `mduMtlo`).
- `A`, input, 32: forwarded rs value.
- `B`, input, 32: forwarded rt value.
- `Busy`, output, 1: high while a mult/div is in progress.
- `HI`, output, 32: architectural HI register.
- `LO`, output, 32: architectural LO register.

## Operation
- FSM states: IDLE and RUN. A 4-bit down-counter `cnt` and a 64-bit `pend_hi`/`pend_lo` result are held.
- **IDLE, `MDUEN`=1, mult/multu/div/divu:**
  - Compute the result from A/B and latch it into `pend`.
  - Load `cnt` with the latency.
  - Go to RUN.
- **IDLE, `MDUEN`=1, mthi:** `HI`<=A at this edge. FSM stays in IDLE and `Busy` stays 0.
- **IDLE, `MDUEN`=1, mtlo:** `LO`<=A at this edge. FSM stays in IDLE and `Busy` stays 0.
- **RUN:**
  - `cnt` decrements each cycle.
  - On the edge where `cnt`==1, commit `HI`<=`pend_hi`, `LO`<=`pend_lo` and return to IDLE.
- **`MDUEN`=1 while in RUN:** ignored, with no state change. The hazard unit guarantees this never happens, and the bench flags it.
- **`MDUEN`=1 with any other `MDUCtrl` value:** no effect.
- **Arithmetic:**
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero:** full Busy latency still runs, and HI/LO are left unchanged.
- **Reads:** mfhi/mflo read `HI`/`LO` directly via `EResultSel`. The block does no read forwarding; stall logic holds mf* while `Busy`.

## Timing
- **Reset** (`reset_n`=0 at an edge) gives:
  - IDLE, `cnt`=0, `Busy`=0;
  - `HI`=0, `LO`=0, `pend`=0.
- **Reset mid-operation:** aborts immediately and the pending result is discarded.
- **Command in cycle 0 (IDLE):** `Busy`=1 in cycles 1..N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- **Commit:** HI/LO take the new values on the edge ending cycle N. They are visible in cycle N+1, when `Busy`=0.
- **Back-to-back:** a new command is accepted in cycle N+1, with no dead cycle.
- **Stall contract:** the hazard unit stalls any MDU instruction in D while `Busy`=1, or while the E-stage instruction has `MDUEN`=1 with a mult/div code. `Busy` is registered, so no combinational path exists from inputs to `Busy`.
- **mthi/mtlo latency:** 1 cycle; the new value is visible in the cycle after issue.
- **Old-value window:** until commit, HI/LO keep their old values.

## Structure
- The `mdu*` opcode constants live in the shared `define.v`, next to the `alu*`/`sl*` codes: mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6, none=0.
- Sub-module `mdu_arith`: purely combinational.
  - Inputs: A, B, op.
  - Outputs: 64-bit result and a `div_zero` flag.
  - Keeps the signed/unsigned product and division out of the FSM.
- `mult_div_unit` holds the FSM, counter and HI/LO registers.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles, then release → HI=0, LO=0, Busy=0.
- **mult:** A=0xFFFFFFFE (-2), B=3 → Busy high exactly cycles 1–5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu then divu:**
  - multu with A=0xFFFFFFFE, B=3 → HI=0x00000002, LO=0xFFFFFFFA.
  - Issue divu with A=100, B=7 in the first idle cycle → Busy cycles 1–10; HI=2, LO=14.
- **Signed div and div-by-zero:**
  - div with A=-7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then div with B=0 → 10 Busy cycles; HI/LO unchanged.
- **mthi/mtlo:**
  - mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO updated one cycle after each issue; Busy never asserted.
  - MDUEN pulsed during Busy → ignored, and the final result is unaffected.
- **Reset mid-op:** start div, assert reset_n=0 in cycle 4 → next cycle Busy=0, HI=LO=0, and no commit at cycle 10.
